mips_stage_ex_muldiv: RTL and testbench

Iterative multiply/divide execute unit with architectural HI/LO registers. It sits beside the ALU in the execute stage and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from the RegEx pipeline register. It stalls the front of the pipeline only when a HI/LO-dependent instruction arrives while an operation is in flight. It generalises the single-cycle execute datapath to a configurable word width and a configurable number of bits processed per cycle.

---
 rtl/mips_stage_ex_muldiv.sv | 164 ++++++++++++++++
 tb/tb_mips_stage_ex_muldiv.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_stage_ex_muldiv.sv
// Iterative multiply/divide unit for the MIPS execute stage with architectural HI/LO.
// Shift-add multiply and restoring divide retire BITS_PER_CYCLE bits per RUN cycle.
`timescale 1ns/1ps
module mips_stage_ex_muldiv #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic [1:0]       ctrl,
    input  logic             opValid,
    input  logic [2:0]       op,
    input  logic             opSel,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned ITER = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int unsigned PW   = WIDTH + BITS_PER_CYCLE;
    localparam int unsigned AW   = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, SIGN} state_t;

    logic clk, rst;
    assign clk = ctrl[0];
    assign rst = ctrl[1];

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [AW-1:0]    acc, acc_nxt;
    logic [WIDTH:0]   rem, rem_nxt;
    logic [WIDTH-1:0] opd, hi_nxt, lo_nxt;
    logic             is_div, div0, neg_q, neg_r;

    logic             is_md, sgn, accept, neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b, quot;
    logic [PW-1:0]    partial, sum;
    logic [WIDTH:0]   step_r;
    logic [WIDTH-1:0] step_q;
    logic [AW-1:0]    prod;

    // Operand decode and magnitude extraction for signed ops
    assign is_md  = opValid && (op >= 3'd1) && (op <= 3'd4);
    assign sgn    = (op == 3'd1) || (op == 3'd3);
    assign accept = is_md && (state == IDLE) && !flush;
    assign neg_a  = sgn && srcA[WIDTH-1];
    assign neg_b  = sgn && srcB[WIDTH-1];
    assign mag_a  = neg_a ? -srcA : srcA;
    assign mag_b  = neg_b ? -srcB : srcB;
    assign quot   = acc[WIDTH-1:0];

    assign busy   = (state != IDLE);
    assign stall  = opValid && (op != 3'd0) && (state != IDLE);
    assign result = (opValid && (op == 3'd7)) ? (opSel ? hi : lo) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        rem_nxt   = rem;
        hi_nxt    = hi;
        lo_nxt    = lo;
        partial   = '0;
        sum       = '0;
        step_r    = '0;
        step_q    = '0;
        prod      = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                    rem_nxt   = '0;
                    acc_nxt   = {{WIDTH{1'b0}}, ((op >= 3'd3) ? mag_a : mag_b)};
                end else if (opValid && !flush && (op == 3'd5)) begin
                    hi_nxt = srcA;
                end else if (opValid && !flush && (op == 3'd6)) begin
                    lo_nxt = srcA;
                end
            end
            RUN: begin
                cnt_nxt = cnt + CW'(1);
                if (is_div) begin
                    // Restoring divide: shift in dividend bits, subtract when it fits
                    step_r = rem;
                    step_q = quot;
                    for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
                        step_r = {step_r[WIDTH-1:0], step_q[WIDTH-1]};
                        step_q = {step_q[WIDTH-2:0], 1'b0};
                        if (step_r >= {1'b0, opd}) begin
                            step_r    = step_r - {1'b0, opd};
                            step_q[0] = 1'b1;
                        end
                    end
                    rem_nxt = step_r;
                    acc_nxt = {acc[AW-1:WIDTH], step_q};
                end else begin
                    // Shift-add: multiplier occupies the low half and drains out to the right
                    for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
                        if (acc[j]) partial = partial + (PW'(opd) << j);
                    end
                    sum     = PW'(acc[AW-1:WIDTH]) + partial;
                    acc_nxt = AW'({sum, acc[WIDTH-1:0]} >> BITS_PER_CYCLE);
                end
                if (cnt == CW'(ITER - 1)) state_nxt = SIGN;
            end
            SIGN: begin
                state_nxt = IDLE;
                if (is_div) begin
                    lo_nxt = div0 ? '1 : (neg_q ? -quot : quot);
                    hi_nxt = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                end else begin
                    prod             = neg_q ? -acc : acc;
                    {hi_nxt, lo_nxt} = prod;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A flush abandons the operation and suppresses its HI/LO write
        if (flush && (state != IDLE)) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            hi_nxt    = hi;
            lo_nxt    = lo;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            rem    <= '0;
            opd    <= '0;
            hi     <= '0;
            lo     <= '0;
            is_div <= 1'b0;
            div0   <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            acc <= acc_nxt;
            rem <= rem_nxt;
            hi  <= hi_nxt;
            lo  <= lo_nxt;
            if (accept) begin
                opd    <= (op >= 3'd3) ? mag_b : mag_a;
                is_div <= (op >= 3'd3);
                div0   <= (srcB == '0);
                neg_q  <= sgn && (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
                neg_r  <= neg_a;
            end
        end
    end
endmodule

// File: tb/tb_mips_stage_ex_muldiv.sv
// Bench for mips_stage_ex_muldiv: 32/1 and 32/4 instances share inputs and are
// checked against a 64-bit arithmetic reference of MIPS mult/div semantics.
`timescale 1ns/1ps
module tb_mips_stage_ex_muldiv;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  ctrl;
    logic        opValid, opSel, flush;
    logic [2:0]  op;
    logic [31:0] srcA, srcB;
    logic        stall, busy, stall4, busy4;
    logic [31:0] result, hi, lo, result4, hi4, lo4;
    int          n_tests = 0;
    int          n_fail  = 0;

    assign ctrl = {rst, clk};
    always #5 clk = ~clk;

    mips_stage_ex_muldiv #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
        .ctrl(ctrl), .opValid(opValid), .op(op), .opSel(opSel), .srcA(srcA), .srcB(srcB),
        .flush(flush), .stall(stall), .busy(busy), .result(result), .hi(hi), .lo(lo));

    mips_stage_ex_muldiv #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
        .ctrl(ctrl), .opValid(opValid), .op(op), .opSel(opSel), .srcA(srcA), .srcB(srcB),
        .flush(flush), .stall(stall4), .busy(busy4), .result(result4), .hi(hi4), .lo(lo4));

    // Reference: {HI,LO} for ops 1..4 using wide integer arithmetic
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd1:    r = 64'(sa * sb);
            3'd2:    r = {32'd0, a} * {32'd0, b};
            3'd3:    r = (b == 32'd0) ? {a, 32'hFFFFFFFF} : {32'(sa % sb), 32'(sa / sb)};
            3'd4:    r = (b == 32'd0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one mult/div in the current (idle) cycle, keep op-0 traffic during RUN, wait for both units
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] e;
        int          nb, nb4;
        logic        stall_bad;
        e = model(o, a, b);
        opValid = 1'b1; op = o; srcA = a; srcB = b; flush = 1'b0;
        #1;
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL issue_stall op=%0d: got %0b want 0", o, stall); end
        cyc();
        op = 3'd0; srcA = $urandom; srcB = $urandom;
        #1;
        nb = 0; nb4 = 0; stall_bad = 1'b0;
        while ((busy || busy4) && nb < 100) begin
            if (stall !== 1'b0 || stall4 !== 1'b0) stall_bad = 1'b1;
            if (busy)  nb++;
            if (busy4) nb4++;
            cyc();
            #1;
        end
        n_tests++;
        if (stall_bad !== 1'b0) begin n_fail++; $display("FAIL op0_stall op=%0d: op-0 instruction saw stall=1, want 0", o); end
        n_tests++;
        if (nb != 33) begin n_fail++; $display("FAIL busy_cycles_bpc1 op=%0d: got %0d want 33", o, nb); end
        n_tests++;
        if (nb4 != 9) begin n_fail++; $display("FAIL busy_cycles_bpc4 op=%0d: got %0d want 9", o, nb4); end
        n_tests++;
        if ({hi, lo} !== e) begin
            n_fail++; $display("FAIL hilo_bpc1 op=%0d a=%h b=%h: got %h_%h want %h_%h", o, a, b, hi, lo, e[63:32], e[31:0]);
        end
        n_tests++;
        if ({hi4, lo4} !== e) begin
            n_fail++; $display("FAIL hilo_bpc4 op=%0d a=%h b=%h: got %h_%h want %h_%h", o, a, b, hi4, lo4, e[63:32], e[31:0]);
        end
        op = 3'd7; opSel = 1'b0;
        #1;
        n_tests++;
        if (result !== e[31:0] || result4 !== e[31:0]) begin
            n_fail++; $display("FAIL mflo op=%0d: got %h/%h want %h", o, result, result4, e[31:0]);
        end
        opSel = 1'b1;
        #1;
        n_tests++;
        if (result !== e[63:32]) begin n_fail++; $display("FAIL mfhi op=%0d: got %h want %h", o, result, e[63:32]); end
    endtask

    task automatic test_reset();
        opValid = 1'b1; op = 3'd7; opSel = 1'b1; flush = 1'b0; srcA = 32'h1; srcB = 32'h2;
        #3;
        n_tests++;
        if (busy !== 1'b0 || busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b/%0b want 0", busy, busy4); end
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", stall); end
        n_tests++;
        if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL reset_hilo: got %h_%h want 0", hi, lo); end
        n_tests++;
        if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
        @(negedge clk);
        rst = 1'b0;
        cyc();
        op = 3'd0; opValid = 1'b0;
    endtask

    typedef struct { logic [2:0] o; logic [31:0] a, b, h, l; } vec_t;

    task automatic test_directed();
        vec_t v[8];
        v[0] = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
        v[1] = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        v[2] = '{3'd4, 32'd7,        32'd2,        32'd1,        32'd3};
        v[3] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
        v[4] = '{3'd4, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
        v[5] = '{3'd3, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF};
        v[6] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        v[7] = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        for (int i = 0; i < 8; i++) begin
            run_op(v[i].o, v[i].a, v[i].b);
            n_tests++;
            if (hi !== v[i].h || lo !== v[i].l || hi4 !== v[i].h || lo4 !== v[i].l) begin
                n_fail++; $display("FAIL directed_%0d: got %h_%h / %h_%h want %h_%h", i, hi, lo, hi4, lo4, v[i].h, v[i].l);
            end
        end
    endtask

    // MFLO held in EX behind a MULT stalls until busy falls, then reads the new LO
    task automatic test_mflo_stall();
        int ns;
        opValid = 1'b1; op = 3'd1; srcA = 32'hFFFFFFFE; srcB = 32'd3; flush = 1'b0;
        cyc();
        opValid = 1'b0; op = 3'd0;
        #1;
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL mflo_busy_after_accept: got %0b want 1", busy); end
        cyc();
        opValid = 1'b1; op = 3'd7; opSel = 1'b0;
        #1;
        ns = 0;
        while (stall && ns < 100) begin
            ns++;
            cyc();
            #1;
        end
        n_tests++;
        if (ns != 32) begin n_fail++; $display("FAIL mflo_stall_cycles: got %0d want 32", ns); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mflo_busy_end: got %0b want 0", busy); end
        n_tests++;
        if (result !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL mflo_result: got %h want fffffffa", result); end
        n_tests++;
        if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mflo_hi: got %h want ffffffff", hi); end
    endtask

    task automatic test_mt_flush();
        int nb;
        opValid = 1'b1; op = 3'd5; srcA = 32'hABCD; flush = 1'b0;
        cyc();
        op = 3'd6; srcA = 32'h1234;
        #1;
        n_tests++;
        if (hi !== 32'hABCD) begin n_fail++; $display("FAIL mthi: got %h want abcd", hi); end
        cyc();
        op = 3'd7; opSel = 1'b0;
        #1;
        n_tests++;
        if (lo !== 32'h1234 || result !== 32'h1234) begin n_fail++; $display("FAIL mtlo: got lo=%h result=%h want 1234", lo, result); end
        op = 3'd1; srcA = 32'd2; srcB = 32'd3;
        cyc();
        op = 3'd0;
        repeat (9) cyc();
        flush = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_run_busy_before: got %0b want 1", busy); end
        cyc();
        flush = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || lo !== 32'h1234 || hi !== 32'hABCD) begin
            n_fail++; $display("FAIL flush_run: got busy=%0b hi=%h lo=%h want 0/abcd/1234", busy, hi, lo);
        end
        op = 3'd1; srcA = 32'd5; srcB = 32'd7;
        cyc();
        op = 3'd0;
        #1;
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL accept_after_flush: got busy=%0b want 1", busy); end
        nb = 0;
        while ((busy || busy4) && nb < 100) begin nb++; cyc(); #1; end
        n_tests++;
        if (lo !== 32'd35 || hi !== 32'd0) begin n_fail++; $display("FAIL mult_after_flush: got %h_%h want 0_23", hi, lo); end
        // flush together with an accept: flush wins
        op = 3'd2; srcA = 32'd9; srcB = 32'd9; flush = 1'b1;
        cyc();
        op = 3'd0; flush = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || busy4 !== 1'b0) begin n_fail++; $display("FAIL flush_accept: got busy=%0b/%0b want 0", busy, busy4); end
        op = 3'd6; srcA = 32'hDEAD; flush = 1'b1;
        cyc();
        flush = 1'b0; op = 3'd0;
        #1;
        n_tests++;
        if (lo !== 32'd35) begin n_fail++; $display("FAIL flush_mtlo: got %h want 23", lo); end
        // flush in SIGN suppresses the HI/LO write
        op = 3'd1; srcA = 32'd3; srcB = 32'd3;
        cyc();
        op = 3'd0;
        repeat (32) cyc();
        flush = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_sign_busy_before: got %0b want 1", busy); end
        cyc();
        flush = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || lo !== 32'd35 || hi !== 32'd0) begin
            n_fail++; $display("FAIL flush_sign: got busy=%0b hi=%h lo=%h want 0/0/23", busy, hi, lo);
        end
    endtask

    task automatic test_random_back_to_back();
        logic [2:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(1, 4));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                3:       b = -32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(o, a, b);
        end
    endtask

    task automatic test_async_reset();
        opValid = 1'b1; op = 3'd1; srcA = $urandom | 32'h1; srcB = $urandom | 32'h1; flush = 1'b0;
        cyc();
        op = 3'd7; opSel = 1'b1;
        repeat (5) cyc();
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0 || stall !== 1'b0 || busy4 !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_ctl: got busy=%0b stall=%0b busy4=%0b want 0", busy, stall, busy4);
        end
        n_tests++;
        if (hi !== 32'd0 || lo !== 32'd0 || result !== 32'd0 || hi4 !== 32'd0 || lo4 !== 32'd0) begin
            n_fail++; $display("FAIL async_reset_data: got hi=%h lo=%h result=%h want 0", hi, lo, result);
        end
        #2;
        rst = 1'b0;
        cyc();
        #1;
        n_tests++;
        if (stall !== 1'b0 || result !== 32'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mfhi_after_reset: got stall=%0b result=%h busy=%0b want 0/0/0", stall, result, busy);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_mflo_stall();
        test_mt_flush();
        test_random_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
